// File: rtl/smul_operand_sequencer.sv
// -----------------------------------------------------------------------------
// smul_operand_sequencer
//
// Front/back wrapper for the 16-bit sequential shift-add multiplier. Operand
// pairs are buffered in a small FIFO and presented to the multiplier one at a
// time. The multiplier restarts whenever its inputs change, so this block keeps
// mul_mlier/mul_mcand stable from one pop to the next. It ignores mul_valid for
// GUARD cycles after a new pair is driven, captures the product and returns it
// on a valid/ready result port. A pair that never completes is aborted after
// TIMEOUT cycles and returned with out_err=1.
//
// Parameters
//   N       operand width (product is 2N+1 bits)
//   DEPTH   input FIFO entries (power of 2, >= 2)
//   TIMEOUT max cycles spent waiting for mul_valid before aborting
//   GUARD   cycles mul_valid is ignored after a new, different pair is driven
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready       operand pair handshake (in_ready = ~full)
//   in_mlier/in_mcand       incoming operand pair
//   mul_mlier/mul_mcand     registered operands to the multiplier
//   mul_valid/mul_prod      multiplier result
//   out_valid/out_ready     result handshake
//   out_prod                captured product (0 when aborted)
//   out_mlier/out_mcand     operands that produced out_prod
//   out_err                 result was aborted by timeout
//   busy                    work in flight or queued
//   timeout_err             sticky: some pair timed out
//   chk_err                 sticky: product self-check mismatch
//
// Build option
//   SMUL_SEQ_CHECK_EN       when defined, every captured product is compared
//                           against a behavioural multiply; a mismatch sets
//                           chk_err. When undefined, chk_err is tied low.
// -----------------------------------------------------------------------------
module smul_operand_sequencer #(
  parameter int N       = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 40,
  parameter int GUARD   = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_mlier,
  input  logic [N-1:0] in_mcand,
  output logic [N-1:0] mul_mlier,
  output logic [N-1:0] mul_mcand,
  input  logic         mul_valid,
  input  logic [2*N:0] mul_prod,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [2*N:0] out_prod,
  output logic [N-1:0] out_mlier,
  output logic [N-1:0] out_mcand,
  output logic         out_err,
  output logic         busy,
  output logic         timeout_err,
  output logic         chk_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int GW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [2*N-1:0] mem_q [DEPTH];
  logic [2*N-1:0] mem_d [DEPTH];
  logic [AW:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]    rd_ptr_q, rd_ptr_d;

  state_t         state_q, state_d;
  logic [N-1:0]   mul_mlier_q, mul_mlier_d;
  logic [N-1:0]   mul_mcand_q, mul_mcand_d;
  logic [GW-1:0]  guard_q, guard_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           last_ok_q, last_ok_d;

  logic           out_valid_q, out_valid_d;
  logic [2*N:0]   out_prod_q, out_prod_d;
  logic [N-1:0]   out_mlier_q, out_mlier_d;
  logic [N-1:0]   out_mcand_q, out_mcand_d;
  logic           out_err_q, out_err_d;
  logic           timeout_err_q, timeout_err_d;

  // ---------------------------------------------------------------------------
  // FIFO status and push side
  // ---------------------------------------------------------------------------
  logic           fifo_empty;
  logic           fifo_full;
  logic           push;
  logic           pop;
  logic [2*N-1:0] head;
  logic [N-1:0]   head_mlier;
  logic [N-1:0]   head_mcand;
  logic           head_repeat;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push       = in_valid && !fifo_full;

  assign head       = mem_q[rd_ptr_q[AW-1:0]];
  assign head_mlier = head[2*N-1:N];
  assign head_mcand = head[N-1:0];

  // A pair identical to the last successfully completed one leaves the
  // multiplier inputs unchanged, so its done state is already valid.
  assign head_repeat = last_ok_q && (head_mlier == out_mlier_q) &&
                       (head_mcand == out_mcand_q);

  always_comb begin
    // NOTE: every variable written here gets its default first, so no path can
    // leave it unassigned and infer a latch.
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = {in_mlier, in_mcand};
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
  end

`ifdef SMUL_SEQ_CHECK_EN
  logic           chk_err_q, chk_err_d;
  logic [2*N-1:0] chk_prod;
  assign chk_prod = (2*N)'(mul_mlier_q) * (2*N)'(mul_mcand_q);
`endif

  // ---------------------------------------------------------------------------
  // Sequencing FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    rd_ptr_d      = rd_ptr_q;
    mul_mlier_d   = mul_mlier_q;
    mul_mcand_d   = mul_mcand_q;
    guard_d       = guard_q;
    cnt_d         = cnt_q;
    last_ok_d     = last_ok_q;
    out_valid_d   = out_valid_q;
    out_prod_d    = out_prod_q;
    out_mlier_d   = out_mlier_q;
    out_mcand_d   = out_mcand_q;
    out_err_d     = out_err_q;
    timeout_err_d = timeout_err_q;
    pop           = 1'b0;
`ifdef SMUL_SEQ_CHECK_EN
    chk_err_d     = chk_err_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        pop = !fifo_empty;
      end

      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (guard_q != '0) begin
          // The multiplier may still be flagging the previous pair's result.
          guard_d = guard_q - GW'(1);
        end else if (mul_valid) begin
          out_prod_d  = mul_prod;
          out_mlier_d = mul_mlier_q;
          out_mcand_d = mul_mcand_q;
          out_err_d   = 1'b0;
          out_valid_d = 1'b1;
          last_ok_d   = 1'b1;
          state_d     = S_HOLD;
`ifdef SMUL_SEQ_CHECK_EN
          if (mul_prod != {1'b0, chk_prod}) chk_err_d = 1'b1;
`endif
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          out_prod_d    = '0;
          out_mlier_d   = mul_mlier_q;
          out_mcand_d   = mul_mcand_q;
          out_err_d     = 1'b1;
          out_valid_d   = 1'b1;
          timeout_err_d = 1'b1;
          last_ok_d     = 1'b0;
          state_d       = S_HOLD;
        end
      end

      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          pop         = !fifo_empty;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Shared pop path for IDLE and the HOLD handshake: the only place the
    // multiplier operands ever change.
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + (AW+1)'(1);
      mul_mlier_d = head_mlier;
      mul_mcand_d = head_mcand;
      guard_d     = head_repeat ? '0 : GW'(GUARD);
      cnt_d       = '0;
      state_d     = S_WAIT;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: FIFO storage is not reset; the pointers alone define which entries
  // are meaningful, so stale data is never observed.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  // NOTE: non-blocking assignments for all state so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      state_q       <= S_IDLE;
      mul_mlier_q   <= '0;
      mul_mcand_q   <= '0;
      guard_q       <= '0;
      cnt_q         <= '0;
      last_ok_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      out_prod_q    <= '0;
      out_mlier_q   <= '0;
      out_mcand_q   <= '0;
      out_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
`ifdef SMUL_SEQ_CHECK_EN
      chk_err_q     <= 1'b0;
`endif
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      state_q       <= state_d;
      mul_mlier_q   <= mul_mlier_d;
      mul_mcand_q   <= mul_mcand_d;
      guard_q       <= guard_d;
      cnt_q         <= cnt_d;
      last_ok_q     <= last_ok_d;
      out_valid_q   <= out_valid_d;
      out_prod_q    <= out_prod_d;
      out_mlier_q   <= out_mlier_d;
      out_mcand_q   <= out_mcand_d;
      out_err_q     <= out_err_d;
      timeout_err_q <= timeout_err_d;
`ifdef SMUL_SEQ_CHECK_EN
      chk_err_q     <= chk_err_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready    = !fifo_full;
  assign mul_mlier   = mul_mlier_q;
  assign mul_mcand   = mul_mcand_q;
  assign out_valid   = out_valid_q;
  assign out_prod    = out_prod_q;
  assign out_mlier   = out_mlier_q;
  assign out_mcand   = out_mcand_q;
  assign out_err     = out_err_q;
  assign timeout_err = timeout_err_q;
  assign busy        = (state_q != S_IDLE) || !fifo_empty;

`ifdef SMUL_SEQ_CHECK_EN
  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_smul_operand_sequencer.sv
// -----------------------------------------------------------------------------
// tb_smul_operand_sequencer
//
// Directed and randomized stimulus for smul_operand_sequencer. A behavioural
// model of the sequential multiplier (restarts on any operand change, done N
// cycles later) sits on the mul_* side. Expected results come from a queue of
// accepted pairs and plain arithmetic.
// -----------------------------------------------------------------------------
module tb_smul_operand_sequencer;

  localparam int N       = 16;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 40;
  localparam int GUARD   = 2;
  localparam int PW      = 2*N + 1;

`ifdef SMUL_SEQ_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    bit           to;   // expected to time out
    bit           bad;  // multiplier model returns a corrupted product
  } pair_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_mlier = '0;
  logic [N-1:0]  in_mcand = '0;
  logic [N-1:0]  mul_mlier;
  logic [N-1:0]  mul_mcand;
  logic          mul_valid;
  logic [PW-1:0] mul_prod;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] out_prod;
  logic [N-1:0]  out_mlier;
  logic [N-1:0]  out_mcand;
  logic          out_err;
  logic          busy;
  logic          timeout_err;
  logic          chk_err;

  always #5 clock = ~clock;

  smul_operand_sequencer #(
    .N(N), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .GUARD(GUARD)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mlier(in_mlier), .in_mcand(in_mcand),
    .mul_mlier(mul_mlier), .mul_mcand(mul_mcand),
    .mul_valid(mul_valid), .mul_prod(mul_prod),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_prod(out_prod), .out_mlier(out_mlier), .out_mcand(out_mcand),
    .out_err(out_err), .busy(busy),
    .timeout_err(timeout_err), .chk_err(chk_err)
  );

  // ---------------------------------------------------------------------------
  // Multiplier model: restarts when its inputs change, valid N cycles later.
  // ---------------------------------------------------------------------------
  logic [N-1:0] m_a = '0;
  logic [N-1:0] m_b = '0;
  int           m_cnt = 0;
  bit           force_invalid = 1'b0;
  bit           corrupt = 1'b0;

  always @(posedge clock) begin
    if (mul_mlier !== m_a || mul_mcand !== m_b) begin
      m_a   <= mul_mlier;
      m_b   <= mul_mcand;
      m_cnt <= 0;
    end else if (m_cnt < N) begin
      m_cnt <= m_cnt + 1;
    end
  end

  assign mul_valid = (m_cnt == N) && !force_invalid;
  assign mul_prod  = {1'b0, 32'(m_a) * 32'(m_b)} ^ PW'(corrupt);

  // ---------------------------------------------------------------------------
  // Reference model and helpers
  // ---------------------------------------------------------------------------
  int    n_vec = 0;
  int    n_err = 0;
  pair_t exp_q[$];

  function automatic logic [PW-1:0] ref_prod(input pair_t p);
    logic [PW-1:0] r;
    r = PW'(p.a) * PW'(p.b);
    if (p.bad) r = r ^ PW'(1);
    if (p.to)  r = '0;
    return r;
  endfunction

  function automatic logic [N-1:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      default: return N'($urandom);
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts just after a rising edge; ends just after the edge that sampled it.
  task automatic push(input logic [N-1:0] a, input logic [N-1:0] b,
                      input bit to, input bit bad, output bit acc);
    pair_t p;
    in_valid = 1'b1;
    in_mlier = a;
    in_mcand = b;
    @(negedge clock);
    acc = in_ready;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    if (acc) begin
      p.a = a; p.b = b; p.to = to; p.bad = bad;
      exp_q.push_back(p);
    end
  endtask

  // Waits (bounded) for out_valid and compares against the oldest accepted
  // pair. Ends on a falling edge with out_valid still pending.
  task automatic wait_result(input string tag, input int budget, output int lat);
    pair_t p;
    @(negedge clock);
    lat = 1;
    while (!out_valid && lat < budget) begin
      @(negedge clock);
      lat++;
    end
    check({tag, "_valid"}, 64'(out_valid), 64'(1));
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check({tag, "_unexpected"}, 64'(exp_q.size()), 64'(1));
      end else begin
        p = exp_q.pop_front();
        check({tag, "_prod"},  64'(out_prod),  64'(ref_prod(p)));
        check({tag, "_err"},   64'(out_err),   64'(p.to));
        check({tag, "_mlier"}, 64'(out_mlier), 64'(p.a));
        check({tag, "_mcand"}, 64'(out_mcand), 64'(p.b));
      end
    end
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    bit           acc;
    int           lat;
    int           n_acc;
    int           burst;
    logic [N-1:0] a, b, last_a, last_b;

    // Reset values
    reset = 1'b1;
    @(posedge clock);
    #1;
    @(negedge clock);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_busy",      64'(busy),      64'(0));
    check("rst_in_ready",  64'(in_ready),  64'(1));
    check("rst_mul_mlier", 64'(mul_mlier), 64'(0));
    check("rst_mul_mcand", 64'(mul_mcand), 64'(0));
    check("rst_out_prod",  64'(out_prod),  64'(0));
    check("rst_tmo_err",   64'(timeout_err), 64'(0));
    check("rst_chk_err",   64'(chk_err),   64'(0));
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Simple product and nominal latency
    push(16'd3, 16'd5, 1'b0, 1'b0, acc);
    wait_result("t35", 24, lat);
    check("t35_lat_min", 64'(lat >= N), 64'(1));
    accept();

    // Largest operands; operands held steady while the result waits
    push(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, acc);
    wait_result("tmax", 30, lat);
    check("tmax_const", 64'(out_prod), 64'(33'h0_FFFE_0001));
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("tmax_hold_valid", 64'(out_valid), 64'(1));
      check("tmax_hold_mlier", 64'(mul_mlier), 64'(16'hFFFF));
      check("tmax_hold_mcand", 64'(mul_mcand), 64'(16'hFFFF));
    end
    accept();

    // Repeated identical pair completes without a multiplier restart
    push(16'd7, 16'd9, 1'b0, 1'b0, acc);
    push(16'd7, 16'd9, 1'b0, 1'b0, acc);
    wait_result("rep1", 30, lat);
    accept();
    wait_result("rep2", 30, lat);
    check("rep2_lat", 64'(lat <= 3), 64'(1));
    check("rep2_mul_mlier", 64'(mul_mlier), 64'(7));
    check("rep2_mul_mcand", 64'(mul_mcand), 64'(9));
    accept();

    // Back-pressure: operand registers plus DEPTH entries
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      push(rand_op(), rand_op(), 1'b0, 1'b0, acc);
      n_acc += int'(acc);
    end
    check("bp_accepted", 64'(n_acc), 64'(DEPTH + 1));
    @(negedge clock);
    check("bp_in_ready", 64'(in_ready), 64'(0));
    for (int i = 0; i < DEPTH + 1; i++) begin
      wait_result("bp_drain", 40, lat);
      accept();
    end
    check("bp_empty_busy", 64'(busy), 64'(0));

    // Timeout, then normal operation resumes
    force_invalid = 1'b1;
    push(16'h1234, 16'h5678, 1'b1, 1'b0, acc);
    wait_result("tmo", TIMEOUT + 10, lat);
    check("tmo_lat", 64'((lat >= TIMEOUT) && (lat <= TIMEOUT + 4)), 64'(1));
    check("tmo_sticky", 64'(timeout_err), 64'(1));
    accept();
    force_invalid = 1'b0;
    push(16'd11, 16'd13, 1'b0, 1'b0, acc);
    wait_result("post_tmo", 30, lat);
    check("post_tmo_prod", 64'(out_prod), 64'(143));
    accept();

    // Randomized bursts, occasionally repeating the previous pair
    last_a = 16'd11;
    last_b = 16'd13;
    for (int it = 0; it < 20; it++) begin
      burst = $urandom_range(1, 3);
      for (int k = 0; k < burst; k++) begin
        if ($urandom_range(0, 9) < 3) begin
          a = last_a;
          b = last_b;
        end else begin
          a = rand_op();
          b = rand_op();
        end
        push(a, b, 1'b0, 1'b0, acc);
        check("rnd_accept", 64'(acc), 64'(1));
        last_a = a;
        last_b = b;
      end
      while (exp_q.size() > 0) begin
        wait_result("rnd", 40, lat);
        repeat ($urandom_range(0, 3)) @(negedge clock);
        check("rnd_hold_valid", 64'(out_valid), 64'(1));
        accept();
      end
    end
    check("rnd_tmo_sticky", 64'(timeout_err), 64'(1));

    // Reset during WAIT with three pairs queued behind the active one
    for (int i = 0; i < 4; i++) push(16'(100 + i), 16'(200 + i), 1'b0, 1'b0, acc);
    @(negedge clock);
    check("mid_busy", 64'(busy), 64'(1));
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clock);
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check("mid_rst_busy",      64'(busy),      64'(0));
    check("mid_rst_in_ready",  64'(in_ready),  64'(1));
    check("mid_rst_mul_mlier", 64'(mul_mlier), 64'(0));
    check("mid_rst_mul_mcand", 64'(mul_mcand), 64'(0));
    check("mid_rst_out_mlier", 64'(out_mlier), 64'(0));
    check("mid_rst_tmo_err",   64'(timeout_err), 64'(0));
    repeat (30) @(negedge clock);
    check("mid_rst_no_replay", 64'(out_valid), 64'(0));
    check("mid_rst_idle",      64'(busy),      64'(0));
    @(posedge clock);
    #1;

    // Corrupted product: passed through unchanged, flagged when checking is on
    corrupt = 1'b1;
    push(16'd21, 16'd2, 1'b0, 1'b1, acc);
    wait_result("corrupt", 30, lat);
    check("corrupt_chk_err", 64'(chk_err), 64'(CHK_EN));
    accept();
    corrupt = 1'b0;
    push(16'd100, 16'd200, 1'b0, 1'b0, acc);
    wait_result("after_corrupt", 30, lat);
    check("after_corrupt_chk_err", 64'(chk_err), 64'(CHK_EN));
    accept();

    // Sticky flags clear only on reset
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("final_chk_err", 64'(chk_err),     64'(0));
    check("final_tmo_err", 64'(timeout_err), 64'(0));
    check("final_busy",    64'(busy),        64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute bound on run time
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
